// File: rtl/fios_operand_server.sv
// fios_operand_server: responder side of the FIOS Montgomery multiplier's
// fetch/push handshake. Buffers host-loaded operands a, b and p, serves them
// to the multiplier on request, captures result words and streams them back
// to the host over a valid/ready interface.
module fios_operand_server #(
    parameter int s     = 8,
    parameter int PE_NB = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  load_valid_i,
    input  logic [1:0]            load_sel_i,
    input  logic [16:0]           load_data_i,
    output logic                  load_ready_o,
    input  logic                  start_i,
    output logic                  start_o,
    input  logic                  a_shift_i,
    input  logic                  b_fetch_i,
    input  logic                  p_fetch_i,
    input  logic                  RES_push_i,
    input  logic                  done_i,
    input  logic [16:0]           RES_i,
    output logic [PE_NB*17-1:0]   a_o,
    output logic [16:0]           b_o,
    output logic [16:0]           p_o,
    output logic                  res_valid_o,
    output logic [16:0]           res_data_o,
    input  logic                  res_ready_i,
    output logic                  busy_o,
    output logic                  err_o
);

    // Counter width holds 0..s, pointer width holds 0..s-1, the a window base
    // can reach the first multiple of PE_NB at or above s.
    localparam int CW      = $clog2(s + 1);
    localparam int PW      = (s > 1) ? $clog2(s) : 1;
    localparam int AW      = $clog2(s + PE_NB);
    localparam int A_MAX_I = ((s + PE_NB - 1) / PE_NB) * PE_NB;

    localparam logic [CW-1:0] S_C    = CW'(s);
    localparam logic [PW-1:0] LAST_P = PW'(s - 1);
    localparam logic [AW-1:0] A_MAX  = AW'(A_MAX_I);
    localparam logic [AW-1:0] A_STEP = AW'(PE_NB);
    localparam logic [AW:0]   S_A    = (AW + 1)'(s);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   la_q, la_d, lb_q, lb_d, lp_q, lp_d;
    logic [AW-1:0]   a_base_q, a_base_d;
    logic [PW-1:0]   b_ptr_q, b_ptr_d, p_ptr_q, p_ptr_d;
    logic [CW-1:0]   res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic            err_q, err_d;
    logic            start_q, start_d;
    logic            res_valid_q, res_valid_d;
    logic            a_we_s, b_we_s, p_we_s, res_we_s;
    logic            operands_full_s;

    logic [16:0]     a_mem_q   [s];
    logic [16:0]     b_mem_q   [s];
    logic [16:0]     p_mem_q   [s];
    logic [16:0]     res_mem_q [s];

    assign operands_full_s = (la_q == S_C) && (lb_q == S_C) && (lp_q == S_C);

    // Next-state, pointer, counter and write-enable decode
    always_comb begin
        state_d     = state_q;
        la_d        = la_q;
        lb_d        = lb_q;
        lp_d        = lp_q;
        a_base_d    = a_base_q;
        b_ptr_d     = b_ptr_q;
        p_ptr_d     = p_ptr_q;
        res_wr_d    = res_wr_q;
        res_rd_d    = res_rd_q;
        err_d       = err_q;
        start_d     = 1'b0;
        res_valid_d = 1'b0;
        a_we_s      = 1'b0;
        b_we_s      = 1'b0;
        p_we_s      = 1'b0;
        res_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && operands_full_s) begin
                    state_d  = ST_RUN;
                    start_d  = 1'b1;
                    err_d    = 1'b0;
                    la_d     = {CW{1'b0}};
                    lb_d     = {CW{1'b0}};
                    lp_d     = {CW{1'b0}};
                    a_base_d = {AW{1'b0}};
                    b_ptr_d  = {PW{1'b0}};
                    p_ptr_d  = {PW{1'b0}};
                    res_wr_d = {CW{1'b0}};
                    res_rd_d = {CW{1'b0}};
                end else if (load_valid_i) begin
                    // Words beyond s per operand, and sel 3, fall on the floor.
                    case (load_sel_i)
                        2'd0: begin
                            if (la_q != S_C) begin
                                a_we_s = 1'b1;
                                la_d   = la_q + CW'(1);
                            end else begin
                                la_d   = la_q;
                            end
                        end
                        2'd1: begin
                            if (lb_q != S_C) begin
                                b_we_s = 1'b1;
                                lb_d   = lb_q + CW'(1);
                            end else begin
                                lb_d   = lb_q;
                            end
                        end
                        2'd2: begin
                            if (lp_q != S_C) begin
                                p_we_s = 1'b1;
                                lp_d   = lp_q + CW'(1);
                            end else begin
                                lp_d   = lp_q;
                            end
                        end
                        default: begin
                            la_d = la_q;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // The a window base sticks once it covers the whole operand.
                if (a_shift_i && (a_base_q != A_MAX)) begin
                    a_base_d = a_base_q + A_STEP;
                end else begin
                    a_base_d = a_base_q;
                end
                if (b_fetch_i) begin
                    b_ptr_d = (b_ptr_q == LAST_P) ? {PW{1'b0}} : b_ptr_q + PW'(1);
                end else begin
                    b_ptr_d = b_ptr_q;
                end
                if (p_fetch_i) begin
                    p_ptr_d = (p_ptr_q == LAST_P) ? {PW{1'b0}} : p_ptr_q + PW'(1);
                end else begin
                    p_ptr_d = p_ptr_q;
                end
                if (RES_push_i) begin
                    if (res_wr_q != S_C) begin
                        res_we_s = 1'b1;
                        res_wr_d = res_wr_q + CW'(1);
                    end else begin
                        err_d    = 1'b1;
                    end
                end else begin
                    res_wr_d = res_wr_q;
                end
                if (done_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (res_valid_q && res_ready_i) begin
                    res_rd_d = res_rd_q + CW'(1);
                    if (res_rd_d == res_wr_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (res_wr_q == {CW{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Valid is registered, so it first appears one cycle after DRAIN entry.
        res_valid_d = (state_q == ST_DRAIN) && (state_d == ST_DRAIN) &&
                      (res_rd_d < res_wr_d);
    end

    // State, pointer, flag and memory registers with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            la_q        <= {CW{1'b0}};
            lb_q        <= {CW{1'b0}};
            lp_q        <= {CW{1'b0}};
            a_base_q    <= {AW{1'b0}};
            b_ptr_q     <= {PW{1'b0}};
            p_ptr_q     <= {PW{1'b0}};
            res_wr_q    <= {CW{1'b0}};
            res_rd_q    <= {CW{1'b0}};
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < s; i++) begin
                a_mem_q[i]   <= 17'd0;
                b_mem_q[i]   <= 17'd0;
                p_mem_q[i]   <= 17'd0;
                res_mem_q[i] <= 17'd0;
            end
        end else begin
            state_q     <= state_d;
            la_q        <= la_d;
            lb_q        <= lb_d;
            lp_q        <= lp_d;
            a_base_q    <= a_base_d;
            b_ptr_q     <= b_ptr_d;
            p_ptr_q     <= p_ptr_d;
            res_wr_q    <= res_wr_d;
            res_rd_q    <= res_rd_d;
            err_q       <= err_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            if (a_we_s) begin
                a_mem_q[la_q[PW-1:0]] <= load_data_i;
            end
            if (b_we_s) begin
                b_mem_q[lb_q[PW-1:0]] <= load_data_i;
            end
            if (p_we_s) begin
                p_mem_q[lp_q[PW-1:0]] <= load_data_i;
            end
            if (res_we_s) begin
                res_mem_q[res_wr_q[PW-1:0]] <= RES_i;
            end
        end
    end

    // a window: words past the end of the operand read as zero
    always_comb begin
        logic [AW:0] idx;
        a_o = {(PE_NB * 17){1'b0}};
        for (int j = 0; j < PE_NB; j++) begin
            idx = {1'b0, a_base_q} + (AW + 1)'(j);
            if (idx < S_A) begin
                a_o[17*j +: 17] = a_mem_q[idx[PW-1:0]];
            end else begin
                a_o[17*j +: 17] = 17'd0;
            end
        end
    end

    assign b_o          = b_mem_q[b_ptr_q];
    assign p_o          = p_mem_q[p_ptr_q];
    assign res_data_o   = (res_rd_q < S_C) ? res_mem_q[res_rd_q[PW-1:0]] : 17'd0;
    assign res_valid_o  = res_valid_q;
    assign start_o      = start_q;
    assign err_o        = err_q;
    assign load_ready_o = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);

endmodule
